spi_note_frame_rx: RTL and testbench
====================================

Name: spi_note_frame_rx

Overview:
- SPI slave (mode 0, MSB first) that receives note-event frames from the host MCU and turns them into the decoded note fields plus a one-cycle strobe for the synth core.
- Sits between the board SPI pins and the voice pipeline. It is the producer of the note_status, voice_index, tuning_code, velocity and flag bundle that the voice controller, DDS and ADSR consume.
- Everything runs in the i_clk domain; the SPI pins are oversampled.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on i_sck, i_cs_n and i_mosi (minimum 2).
- NUM_VOICES, 256: frames with voice_index >= NUM_VOICES are rejected as errors.

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCK frequency.
- i_reset  in  1  asynchronous, active-high reset.
- i_sck  in  1  SPI clock from the MCU (asynchronous to i_clk).
- i_cs_n  in  1  SPI chip select, active low (asynchronous).
- i_mosi  in  1  SPI data in (asynchronous).
- o_SPI_note_status  out  1  1 = note on, 0 = note off.
- o_SPI_velocity  out  7  note velocity.
- o_SPI_voice_index  out  8  target voice.
- o_SPI_tuning_code  out  32  DDS phase increment.
- o_SPI_flag  out  1  one-cycle pulse; the fields above are valid in that cycle.
- o_frame_error  out  1  one-cycle pulse when a frame is discarded.
- o_error_count  out  8  saturating count of discarded frames.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0, the FSM goes to WAIT_IDLE, and the shift register and bit counter clear.
  - If reset lands mid-frame, that frame is lost. No flag and no error are produced for it.
- Input handling:
  - All three pins pass through SYNC_STAGES flip-flops.
  - SCK rising edge = synchronized sck is 1 and its previous sample was 0. CS rise and CS fall are detected the same way.
- Frame format (48 bits, MSB first):
  - byte0: bit7 note_status, bits6:0 velocity.
  - byte1: voice_index.
  - bytes2-5: tuning_code[31:0].
- FSM states:
  - WAIT_IDLE: entered after reset. Moves to IDLE only once synchronized cs_n is seen high, so a frame already in progress at reset release is never captured.
  - IDLE: on CS fall, clear the bit counter and the shift register, then go to SHIFT.
  - SHIFT: on each SCK rise, shift synchronized mosi into the LSB and increment the 6-bit bit counter. The counter saturates at 63. On CS rise, go to COMMIT.
  - COMMIT: lasts exactly one cycle, then returns to IDLE. The frame is valid when bit_count == 48 and voice_index < NUM_VOICES.
    - Valid: load all field outputs and pulse o_SPI_flag in that same cycle.
    - Invalid: leave the fields unchanged, pulse o_frame_error, and increment o_error_count (holds at 255).
- Output timing and stability:
  - Fields are registered and hold their last committed value until the next valid frame.
  - o_SPI_flag and o_frame_error are never high in the same cycle, and each is high for exactly 1 cycle.
- Latency: o_SPI_flag rises SYNC_STAGES+2 i_clk cycles after the first i_clk edge that samples i_cs_n high at the pin.
- Boundary cases:
  - SCK rise detected in the same cycle as CS rise: the SCK edge is ignored (CS rise wins).
  - More than 48 SCK edges: the counter saturates at 63, so the frame is an error.
  - Fewer than 48 SCK edges: error.
  - CS fall and CS rise with no clocks in between: error, count 0.
  - CS glitch shorter than SYNC_STAGES cycles: may be missed. This is acceptable and not checked by the bench.
- Back-to-back frames: a CS fall may arrive at the first cycle of IDLE. The minimum CS-high time is 3 i_clk cycles.

Optional Feature:
- Macro SPI_FRAME_CHECKSUM_EN.
- Defined:
  - Frames are 56 bits; byte6 = XOR of bytes 0-5.
  - COMMIT additionally requires bit_count == 56 and a matching checksum. A mismatch is handled as a frame error.
  - The shift register is 56 bits.
- Not defined: 48-bit frames with no checksum, exactly as above.

Decomposition:
- Package midisynth_spi_pkg holds:
  - FRAME_BITS (48, or 56 with the checksum).
  - Field bit offsets: NOTE_STATUS_BIT=47, VEL_MSB=46/LSB=40, VOICE_MSB=39/LSB=32, TUNE_MSB=31/LSB=0. With the checksum, these shift up by 8.
  - The FSM state encoding.
- One sub-module, sync_ff: a SYNC_STAGES-deep synchronizer with asynchronous reset (value 0; cs_n resets to 1). It is instantiated three times and reused elsewhere for any async board inputs.

Test Plan:
- Valid frame: 0xC5,0x03,0x12,0x34,0x56,0x78 at SCK = clk/8 -> one o_SPI_flag pulse with note_status=1, velocity=0x45, voice_index=3, tuning_code=0x12345678; o_frame_error stays 0.
- 40-bit frame, then 49-bit frame -> two o_frame_error pulses, no flag, o_error_count=2, fields unchanged from the previous valid frame.
- Reset pulse at bit 20 while CS stays low, then the remaining bits and a CS rise -> no flag and no error. The next full frame commits correctly.
- Frame with voice_index=0x10 and NUM_VOICES=16 -> o_frame_error pulse, fields unchanged.
- 300 short frames -> o_error_count saturates at 255 with no wrap. Back-to-back valid frames with 3-cycle CS-high gaps -> one flag per frame, each with the correct fields.
- With SPI_FRAME_CHECKSUM_EN: correct byte6 -> flag; byte6 with a single bit flipped -> o_frame_error, no flag.

Source files
------------

// File: rtl/spi_note_frame_rx_pkg.sv
// Shared frame layout and FSM encoding for the SPI note-frame receiver.
// SPI_FRAME_CHECKSUM_EN appends a trailing XOR checksum byte to every frame.
package midisynth_spi_pkg;

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int CSUM_W = 8;
`else
  localparam int CSUM_W = 0;
`endif

  localparam int FRAME_BITS      = 48 + CSUM_W;
  localparam int NOTE_STATUS_BIT = 47 + CSUM_W;
  localparam int VEL_MSB         = 46 + CSUM_W;
  localparam int VEL_LSB         = 40 + CSUM_W;
  localparam int VOICE_MSB       = 39 + CSUM_W;
  localparam int VOICE_LSB       = 32 + CSUM_W;
  localparam int TUNE_MSB        = 31 + CSUM_W;
  localparam int TUNE_LSB        = 0 + CSUM_W;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_COMMIT    = 2'd3
  } frame_state_t;

endpackage

// File: rtl/spi_note_frame_rx_if.sv
// SPI pins plus the decoded note bundle handed to the voice pipeline.
interface spi_note_frame_rx_if;
  logic        i_sck;
  logic        i_cs_n;
  logic        i_mosi;
  logic        o_SPI_note_status;
  logic [6:0]  o_SPI_velocity;
  logic [7:0]  o_SPI_voice_index;
  logic [31:0] o_SPI_tuning_code;
  logic        o_SPI_flag;
  logic        o_frame_error;
  logic [7:0]  o_error_count;

  modport master (
    output i_sck, i_cs_n, i_mosi,
    input  o_SPI_note_status, o_SPI_velocity, o_SPI_voice_index,
    input  o_SPI_tuning_code, o_SPI_flag, o_frame_error, o_error_count
  );

  modport slave (
    input  i_sck, i_cs_n, i_mosi,
    output o_SPI_note_status, o_SPI_velocity, o_SPI_voice_index,
    output o_SPI_tuning_code, o_SPI_flag, o_frame_error, o_error_count
  );
endinterface

// File: rtl/spi_note_frame_rx_sync_ff.sv
// Multi-flop synchronizer for asynchronous board inputs; reset value selectable.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] q_p0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) q_p0 <= {STAGES{RESET_VAL}};
    else         q_p0 <= {q_p0[STAGES-2:0], i_d};
  end

  assign o_q = q_p0[STAGES-1];

endmodule

// File: rtl/spi_note_frame_rx.sv
// SPI mode-0 slave that decodes note-event frames into registered fields plus a strobe.
// Define SPI_FRAME_CHECKSUM_EN for 56-bit frames carrying an XOR checksum byte.
module spi_note_frame_rx
  import midisynth_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_VOICES  = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  spi_note_frame_rx_if.slave bus
);

  localparam logic [8:0] VOICE_LIMIT = 9'(NUM_VOICES);
  // cs_n must read high for longer than the synchronizer flush before the FSM trusts it
  localparam logic [5:0] SETTLE_CNT  = 6'(SYNC_STAGES + 1);

  function automatic logic [5:0] sat_inc_bits(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic sck_p0, cs_n_p0, mosi_p0;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(bus.i_sck), .o_q(sck_p0));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(bus.i_cs_n), .o_q(cs_n_p0));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(bus.i_mosi), .o_q(mosi_p0));

  // ---- p0 -> p1: registered edge detection, mosi kept aligned with sck_rise ----
  logic sck_prev_p1, cs_prev_p1;
  logic sck_rise_p1, cs_rise_p1, cs_fall_p1, mosi_p1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sck_prev_p1 <= 1'b0;
      cs_prev_p1  <= 1'b1;
      sck_rise_p1 <= 1'b0;
      cs_rise_p1  <= 1'b0;
      cs_fall_p1  <= 1'b0;
      mosi_p1     <= 1'b0;
    end else begin
      sck_prev_p1 <= sck_p0;
      cs_prev_p1  <= cs_n_p0;
      sck_rise_p1 <= sck_p0 & ~sck_prev_p1;
      cs_rise_p1  <= cs_n_p0 & ~cs_prev_p1;
      cs_fall_p1  <= ~cs_n_p0 & cs_prev_p1;
      mosi_p1     <= mosi_p0;
    end
  end

  // ---- p1 -> p2: frame FSM and registered outputs ----
  frame_state_t          state_p2;
  logic [5:0]            bit_cnt_p2;
  logic [FRAME_BITS-1:0] shreg_p2;
  logic                  frame_ok;

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0] csum_calc;
  assign csum_calc = shreg_p2[55:48] ^ shreg_p2[47:40] ^ shreg_p2[39:32] ^
                     shreg_p2[31:24] ^ shreg_p2[23:16] ^ shreg_p2[15:8];
  assign frame_ok = (bit_cnt_p2 == 6'(FRAME_BITS)) &&
                    ({1'b0, shreg_p2[VOICE_MSB:VOICE_LSB]} < VOICE_LIMIT) &&
                    (csum_calc == shreg_p2[7:0]);
`else
  assign frame_ok = (bit_cnt_p2 == 6'(FRAME_BITS)) &&
                    ({1'b0, shreg_p2[VOICE_MSB:VOICE_LSB]} < VOICE_LIMIT);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_p2              <= ST_WAIT_IDLE;
      bit_cnt_p2            <= 6'd0;
      shreg_p2              <= '0;
      bus.o_SPI_note_status <= 1'b0;
      bus.o_SPI_velocity    <= 7'd0;
      bus.o_SPI_voice_index <= 8'd0;
      bus.o_SPI_tuning_code <= 32'd0;
      bus.o_SPI_flag        <= 1'b0;
      bus.o_frame_error     <= 1'b0;
      bus.o_error_count     <= 8'd0;
    end else begin
      bus.o_SPI_flag    <= 1'b0;
      bus.o_frame_error <= 1'b0;
      case (state_p2)
        // bit_cnt doubles as the cs_n-high settle counter while waiting
        ST_WAIT_IDLE: begin
          if (!cs_n_p0) begin
            bit_cnt_p2 <= 6'd0;
          end else if (bit_cnt_p2 == SETTLE_CNT) begin
            bit_cnt_p2 <= 6'd0;
            state_p2   <= ST_IDLE;
          end else begin
            bit_cnt_p2 <= bit_cnt_p2 + 6'd1;
          end
        end
        ST_IDLE: begin
          if (cs_fall_p1) begin
            bit_cnt_p2 <= 6'd0;
            shreg_p2   <= '0;
            state_p2   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise_p1) begin
            state_p2 <= ST_COMMIT;
          end else if (sck_rise_p1) begin
            shreg_p2   <= {shreg_p2[FRAME_BITS-2:0], mosi_p1};
            bit_cnt_p2 <= sat_inc_bits(bit_cnt_p2);
          end
        end
        ST_COMMIT: begin
          state_p2 <= ST_IDLE;
          if (frame_ok) begin
            bus.o_SPI_note_status <= shreg_p2[NOTE_STATUS_BIT];
            bus.o_SPI_velocity    <= shreg_p2[VEL_MSB:VEL_LSB];
            bus.o_SPI_voice_index <= shreg_p2[VOICE_MSB:VOICE_LSB];
            bus.o_SPI_tuning_code <= shreg_p2[TUNE_MSB:TUNE_LSB];
            bus.o_SPI_flag        <= 1'b1;
          end else begin
            bus.o_frame_error <= 1'b1;
            bus.o_error_count <= sat_inc_err(bus.o_error_count);
          end
        end
        default: state_p2 <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_note_frame_rx.sv
// Scoreboard bench for spi_note_frame_rx: directed frames push expected events, a monitor checks them.
`timescale 1ns/1ps
module tb_spi_note_frame_rx;
  import midisynth_spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_note_frame_rx_if bus();

  spi_note_frame_rx #(.SYNC_STAGES(2), .NUM_VOICES(16)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus));

  typedef struct {
    bit          is_flag;
    logic        st;
    logic [6:0]  vel;
    logic [7:0]  voice;
    logic [31:0] tune;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  logic        m_st;
  logic [6:0]  m_vel;
  logic [7:0]  m_voice;
  logic [31:0] m_tune;
  logic [7:0]  m_ecnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 1'b0; m_vel = '0; m_voice = '0; m_tune = '0; m_ecnt = '0;
  endtask

  task automatic expect_flag(input logic st, input logic [6:0] vel,
                             input logic [7:0] v, input logic [31:0] t);
    exp_t e;
    m_st = st; m_vel = vel; m_voice = v; m_tune = t;
    e = '{1'b1, st, vel, v, t, m_ecnt};
    q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    e = '{1'b0, m_st, m_vel, m_voice, m_tune, m_ecnt};
    q.push_back(e);
  endtask

  function automatic logic [63:0] frame(input logic st, input logic [6:0] vel,
                                        input logic [7:0] v, input logic [31:0] t);
    logic [47:0] b;
    b = {st, vel, v, t};
`ifdef SPI_FRAME_CHECKSUM_EN
    return {8'd0, b, b[47:40] ^ b[39:32] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0]};
`else
    return {16'd0, b};
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCK = clk/8; rst_at >= 0 pulses reset after that many bits while CS stays low
  task automatic send(input logic [63:0] d, input int nbits, input int gap, input int rst_at);
    bus.i_cs_n = 1'b0;
    cyc(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (nbits - 1 - i == rst_at) begin
        rst = 1'b1; cyc(2); rst = 1'b0;
        model_reset();
      end
      bus.i_mosi = d[i];
      cyc(4);
      bus.i_sck = 1'b1;
      cyc(4);
      bus.i_sck = 1'b0;
    end
    cyc(4);
    bus.i_cs_n = 1'b1;
    cyc(gap);
  endtask

  // Monitor: every strobe pops one expected event
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.o_SPI_flag || bus.o_frame_error)) begin
      check("flag_err_exclusive", 64'(bus.o_SPI_flag & bus.o_frame_error), 64'd0);
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: flag=%b err=%b with nothing expected",
                 bus.o_SPI_flag, bus.o_frame_error);
      end else begin
        e = q.pop_front();
        check("event_is_flag", 64'(bus.o_SPI_flag), 64'(e.is_flag));
        check("note_status", 64'(bus.o_SPI_note_status), 64'(e.st));
        check("velocity", 64'(bus.o_SPI_velocity), 64'(e.vel));
        check("voice_index", 64'(bus.o_SPI_voice_index), 64'(e.voice));
        check("tuning_code", 64'(bus.o_SPI_tuning_code), 64'(e.tune));
        check("error_count", 64'(bus.o_error_count), 64'(e.ecnt));
      end
    end
  end

  initial begin
    logic [63:0] f;
    bus.i_sck = 1'b0; bus.i_cs_n = 1'b1; bus.i_mosi = 1'b0;
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_fields", {bus.o_SPI_note_status, bus.o_SPI_velocity, bus.o_SPI_voice_index,
                         bus.o_SPI_tuning_code}, 64'd0);
    check("rst_strobes", 64'({bus.o_SPI_flag, bus.o_frame_error}), 64'd0);
    check("rst_errcnt", 64'(bus.o_error_count), 64'd0);
    cyc(10);

    // Reference frame C5 03 12 34 56 78
    expect_flag(1'b1, 7'h45, 8'h03, 32'h12345678);
    send(frame(1'b1, 7'h45, 8'h03, 32'h12345678), FRAME_BITS, 12, -1);

    // Short frame, then one bit too many
    expect_err();
    send(64'h00AB_CDEF_0123, 40, 12, -1);
    expect_err();
    send(64'h1_2345_6789_ABCD, FRAME_BITS + 1, 12, -1);

    // Reset mid-frame: frame discarded silently, everything back to zero
    send(frame(1'b1, 7'h11, 8'h02, 32'hCAFEF00D), FRAME_BITS, 12, 20);
    check("midrst_errcnt", 64'(bus.o_error_count), 64'(m_ecnt));
    check("midrst_tune", 64'(bus.o_SPI_tuning_code), 64'(m_tune));
    expect_flag(1'b0, 7'h7F, 8'h0F, 32'hDEADBEEF);
    send(frame(1'b0, 7'h7F, 8'h0F, 32'hDEADBEEF), FRAME_BITS, 12, -1);

    // voice_index at NUM_VOICES is rejected
    expect_err();
    send(frame(1'b1, 7'h01, 8'h10, 32'h0000_0001), FRAME_BITS, 12, -1);

    // CS pulse with no SCK
    expect_err();
    send(64'd0, 0, 12, -1);

    // Back-to-back with minimum CS-high gap
    expect_flag(1'b1, 7'h00, 8'h00, 32'hFFFF_FFFF);
    send(frame(1'b1, 7'h00, 8'h00, 32'hFFFF_FFFF), FRAME_BITS, 3, -1);
    expect_flag(1'b0, 7'h2A, 8'h07, 32'h8000_0001);
    send(frame(1'b0, 7'h2A, 8'h07, 32'h8000_0001), FRAME_BITS, 3, -1);
    expect_flag(1'b1, 7'h55, 8'h0E, 32'h0F0F_A5A5);
    send(frame(1'b1, 7'h55, 8'h0E, 32'h0F0F_A5A5), FRAME_BITS, 12, -1);

    // Error counter saturation
    for (int k = 0; k < 300; k++) begin
      expect_err();
      send(64'd0, 0, 6, -1);
    end
    expect_flag(1'b0, 7'h33, 8'h09, 32'h0BAD_CAFE);
    send(frame(1'b0, 7'h33, 8'h09, 32'h0BAD_CAFE), FRAME_BITS, 12, -1);

`ifdef SPI_FRAME_CHECKSUM_EN
    f = frame(1'b1, 7'h12, 8'h05, 32'h0246_8ACE);
    expect_flag(1'b1, 7'h12, 8'h05, 32'h0246_8ACE);
    send(f, FRAME_BITS, 12, -1);
    f[3] = ~f[3];
    expect_err();
    send(f, FRAME_BITS, 12, -1);
`else
    f = frame(1'b1, 7'h12, 8'h05, 32'h0246_8ACE);
    expect_flag(1'b1, 7'h12, 8'h05, 32'h0246_8ACE);
    send(f, FRAME_BITS, 12, -1);
`endif

    cyc(40);
    check("pending_expected", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
